// File: rtl/cc_pkg.sv
// Shared condition-code definitions: flag bit positions, condition codes and
// the condition decode function used by the unit and its bench.
package cc_pkg;

    localparam int FLAG_W = 4;
    localparam int FZ     = 0;
    localparam int FC     = 1;
    localparam int FN     = 2;
    localparam int FV     = 3;

    typedef enum logic [3:0] {
        CC_FALSE = 4'h0,
        CC_TRUE1 = 4'h1,
        CC_TRUE2 = 4'h2,
        CC_TRUE3 = 4'h3,
        CC_Z     = 4'h4,
        CC_NZ    = 4'h5,
        CC_C     = 4'h6,
        CC_NC    = 4'h7,
        CC_N     = 4'h8,
        CC_NN    = 4'h9,
        CC_V     = 4'hA,
        CC_NV    = 4'hB,
        CC_GE    = 4'hC,
        CC_LT    = 4'hD,
        CC_GT    = 4'hE,
        CC_LE    = 4'hF
    } cont_e;

    function automatic logic cc_eval(input cont_e c, input logic [FLAG_W-1:0] f);
        logic ge;
        logic r;
        ge = (f[FN] == f[FV]);
        r  = 1'b0;
        case (c)
            CC_FALSE: r = 1'b0;
            CC_TRUE1,
            CC_TRUE2,
            CC_TRUE3: r = 1'b1;
            CC_Z:     r = f[FZ];
            CC_NZ:    r = ~f[FZ];
            CC_C:     r = f[FC];
            CC_NC:    r = ~f[FC];
            CC_N:     r = f[FN];
            CC_NN:    r = ~f[FN];
            CC_V:     r = f[FV];
            CC_NV:    r = ~f[FV];
            CC_GE:    r = ge;
            CC_LT:    r = ~ge;
            CC_GT:    r = ~f[FZ] & ge;
            CC_LE:    r = f[FZ] | ~ge;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cc_flag_stack.sv
// LIFO of SDEPTH flag words for interrupt save/restore; registered full/empty,
// illegal operations (overflow, underflow, push+pop) are ignored and flagged.
module cc_flag_stack
    import cc_pkg::*;
#(
    parameter int SDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FLAG_W-1:0] din_i,
    output logic [FLAG_W-1:0] top_o,
    output logic              pop_ok_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int CW = $clog2(SDEPTH + 1);
    localparam int AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_q, empty_q;
    logic [FLAG_W-1:0] mem_q [SDEPTH];
    logic              push_ok;
    logic [AW-1:0]     wr_idx, rd_idx;

    always_comb begin
        push_ok  = push_i & ~pop_i & ~full_q;
        pop_ok_o = pop_i & ~push_i & ~empty_q;
        err_o    = (push_i & pop_i) | (push_i & full_q) | (pop_i & empty_q);
        cnt_d    = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok_o) begin
            cnt_d = cnt_q - 1'b1;
        end
        wr_idx = AW'(cnt_q);
        rd_idx = AW'(cnt_q - 1'b1);
        top_o  = mem_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(SDEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Contents need no reset: the count alone decides what is readable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx] <= din_i;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/cond_code_unit.sv
// Registered condition-code unit: masked flag capture, forwarded condition
// evaluation (1-cycle tcnd latency) and flag save/restore stack.
module cond_code_unit
    import cc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [DW:0]       aluo,
    input  logic              alu_ovf,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic              eval_valid,
    input  logic [3:0]        cont,
    input  logic              push,
    input  logic              pop,
    output logic              tcnd,
    output logic              tcnd_valid,
    output logic [FLAG_W-1:0] flags,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              flag_err
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [FLAG_W-1:0] alu_flags;
    logic              tcnd_q, tcnd_d;
    logic              tcnd_vld_q;
    logic              flag_err_q;
    logic [FLAG_W-1:0] stk_top;
    logic              stk_pop_ok;
    logic              stk_err;

    // Push always saves the registered flags, so pre-update values are kept
    // when an ALU write lands in the same cycle.
    cc_flag_stack #(
        .SDEPTH (SDEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .pop_i    (pop),
        .din_i    (flags_q),
        .top_o    (stk_top),
        .pop_ok_o (stk_pop_ok),
        .full_o   (stk_full),
        .empty_o  (stk_empty),
        .err_o    (stk_err)
    );

    always_comb begin
        alu_flags     = '0;
        alu_flags[FZ] = (aluo[DW-1:0] == '0);
        alu_flags[FC] = aluo[DW];
        alu_flags[FN] = aluo[DW-1];
        alu_flags[FV] = alu_ovf;

        flags_d = flags_q;
        if (stk_pop_ok) begin
            flags_d = stk_top;
        end else if (alu_valid) begin
            flags_d = (flags_q & ~flag_we) | (alu_flags & flag_we);
        end

        // Evaluate against next flags so a same-cycle update is visible.
        tcnd_d = tcnd_q;
        if (eval_valid) begin
            tcnd_d = cc_eval(cont_e'(cont), flags_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= '0;
            tcnd_q     <= 1'b0;
            tcnd_vld_q <= 1'b0;
            flag_err_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            tcnd_q     <= tcnd_d;
            tcnd_vld_q <= eval_valid;
            flag_err_q <= stk_err;
        end
    end

    assign flags      = flags_q;
    assign tcnd       = tcnd_q;
    assign tcnd_valid = tcnd_vld_q;
    assign flag_err   = flag_err_q;

endmodule

// File: tb/tb_cond_code_unit.sv
// Directed bench for cond_code_unit: a sequential vector table, a condition
// sweep over two flag states, and a reset-during-eval sequence.
module tb_cond_code_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid;
    logic [8:0] aluo;
    logic       alu_ovf;
    logic [3:0] flag_we;
    logic       eval_valid;
    logic [3:0] cont;
    logic       push;
    logic       pop;
    logic       tcnd;
    logic       tcnd_valid;
    logic [3:0] flags;
    logic       stk_full;
    logic       stk_empty;
    logic       flag_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       av;
        logic [8:0] ao;
        logic       ov;
        logic [3:0] we;
        logic       ev;
        logic [3:0] cn;
        logic       ps;
        logic       pp;
        logic [3:0] e_flags;
        logic       e_tcnd;
        logic       e_tv;
        logic       e_full;
        logic       e_empty;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    cond_code_unit #(
        .DW     (8),
        .SDEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .aluo       (aluo),
        .alu_ovf    (alu_ovf),
        .flag_we    (flag_we),
        .eval_valid (eval_valid),
        .cont       (cont),
        .push       (push),
        .pop        (pop),
        .tcnd       (tcnd),
        .tcnd_valid (tcnd_valid),
        .flags      (flags),
        .stk_full   (stk_full),
        .stk_empty  (stk_empty),
        .flag_err   (flag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic av, input logic [8:0] ao, input logic ov, input logic [3:0] we,
                       input logic ev, input logic [3:0] cn, input logic ps, input logic pp,
                       input logic [3:0] ef, input logic et, input logic etv,
                       input logic efu, input logic eem, input logic eer);
        vec_t v;
        v.av = av; v.ao = ao; v.ov = ov; v.we = we; v.ev = ev; v.cn = cn; v.ps = ps; v.pp = pp;
        v.e_flags = ef; v.e_tcnd = et; v.e_tv = etv; v.e_full = efu; v.e_empty = eem; v.e_err = eer;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; aluo = '0; alu_ovf = 1'b0; flag_we = '0;
        eval_valid = 1'b0; cont = '0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [3:0] ef, input logic et,
                             input logic etv, input logic efu, input logic eem, input logic eer);
        chk({tag, ".flags"}, idx, 9'(flags), 9'(ef));
        chk({tag, ".tcnd"}, idx, 9'(tcnd), 9'(et));
        chk({tag, ".tcnd_valid"}, idx, 9'(tcnd_valid), 9'(etv));
        chk({tag, ".stk_full"}, idx, 9'(stk_full), 9'(efu));
        chk({tag, ".stk_empty"}, idx, 9'(stk_empty), 9'(eem));
        chk({tag, ".flag_err"}, idx, 9'(flag_err), 9'(eer));
    endtask

    task automatic sweep(input int base, input logic [15:0] exp_bits);
        logic [15:0] eb;
        eb = exp_bits;
        for (int c = 0; c < 16; c++) begin
            idle_inputs();
            eval_valid = 1'b1;
            cont = 4'(c);
            tick();
            chk("sweep.tcnd", base + c, 9'(tcnd), 9'(eb[c]));
            chk("sweep.tcnd_valid", base + c, 9'(tcnd_valid), 9'h1);
        end
    endtask

    initial begin
        // av   aluo    ov we       ev cont    ps pp | flags   t  tv fu em er
        add(0, 9'h000, 0, 4'b0000, 1, 4'b0100, 0, 0, 4'b0000, 0, 1, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 1, 4'b0001, 0, 0, 4'b0000, 1, 1, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 1, 0);
        add(1, 9'h100, 0, 4'b1111, 1, 4'b0100, 0, 0, 4'b0011, 1, 1, 0, 1, 0);
        add(1, 9'h000, 0, 4'b0010, 1, 4'b0110, 0, 0, 4'b0001, 0, 1, 0, 1, 0);
        add(1, 9'h080, 1, 4'b1111, 1, 4'b1100, 0, 0, 4'b1100, 1, 1, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 1, 4'b1101, 0, 0, 4'b1100, 0, 1, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 1, 4'b1110, 0, 0, 4'b1100, 1, 1, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 1, 4'b1111, 0, 0, 4'b1100, 0, 1, 0, 1, 0);
        add(1, 9'h000, 0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0001, 0, 0, 0, 1, 0);
        add(1, 9'h080, 0, 4'b0100, 0, 4'b0000, 0, 0, 4'b0101, 0, 0, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0101, 0, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0101, 0, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0101, 0, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0101, 0, 0, 1, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0101, 0, 0, 1, 0, 1);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0101, 0, 0, 1, 0, 0);
        add(1, 9'h100, 0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0011, 0, 0, 1, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0101, 0, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0101, 0, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0101, 0, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0101, 0, 0, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0101, 0, 0, 0, 1, 1);
        add(1, 9'h001, 1, 4'b1111, 0, 4'b0000, 0, 0, 4'b1000, 0, 0, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b1000, 0, 0, 0, 0, 0);
        add(1, 9'h001, 0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        // Pop beats the ALU write; the eval sees the restored V.
        add(1, 9'h000, 0, 4'b1111, 1, 4'b1010, 0, 1, 4'b1000, 1, 1, 0, 1, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 0, 4'b1000, 1, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 1, 1, 4'b1000, 1, 0, 0, 0, 1);
        add(1, 9'h001, 0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b1000, 1, 0, 0, 1, 0);
        add(1, 9'h000, 0, 4'b1111, 0, 4'b0000, 1, 0, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 9'h000, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b1000, 1, 0, 0, 1, 0);

        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_all("reset", 0, 4'b0000, 0, 0, 0, 1, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            alu_valid = vecs[i].av; aluo = vecs[i].ao; alu_ovf = vecs[i].ov; flag_we = vecs[i].we;
            eval_valid = vecs[i].ev; cont = vecs[i].cn; push = vecs[i].ps; pop = vecs[i].pp;
            tick();
            check_all("vec", i, vecs[i].e_flags, vecs[i].e_tcnd, vecs[i].e_tv,
                      vecs[i].e_full, vecs[i].e_empty, vecs[i].e_err);
        end

        // Flags 1000 (V only), then 0011 (Z and C).
        sweep(0, 16'hA6AE);
        idle_inputs();
        alu_valid = 1'b1; aluo = 9'h100; flag_we = 4'b1111;
        tick();
        chk("set0011.flags", 0, 9'(flags), 9'h003);
        sweep(16, 16'h9A5E);

        // Load stack and flags, then reset while an eval is in flight.
        idle_inputs();
        push = 1'b1;
        tick();
        chk("prerst.stk_empty", 0, 9'(stk_empty), 9'h0);
        idle_inputs();
        rst = 1'b1;
        alu_valid = 1'b1; aluo = 9'h080; alu_ovf = 1'b1; flag_we = 4'b1111;
        eval_valid = 1'b1; cont = 4'b0001;
        tick();
        check_all("rst_mid", 0, 4'b0000, 0, 0, 0, 1, 0);
        rst = 1'b0;
        idle_inputs();
        pop = 1'b1;
        tick();
        check_all("post_rst_pop", 0, 4'b0000, 0, 0, 0, 1, 1);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
